// File: rtl/cp0_exc_ctrl_pkg.sv
// cp0_defs: shared CP0 register numbers, excepttype/ExcCode values and field positions.
//   Imported by cp0_timer and cp0_exc_ctrl; no ports.
package cp0_defs;
    typedef enum logic [4:0] {
        REG_BADVADDR = 5'd8,
        REG_COUNT    = 5'd9,
        REG_COMPARE  = 5'd11,
        REG_STATUS   = 5'd12,
        REG_CAUSE    = 5'd13,
        REG_EPC      = 5'd14
    } cp0_reg_e;
    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam int ST_IE      = 0;
    localparam int ST_EXL     = 1;
    localparam int CA_EXC_LO  = 2;
    localparam int CA_EXC_HI  = 6;
    localparam int CA_IPSW_LO = 8;
    localparam int CA_IPSW_HI = 9;
    localparam int CA_IPHW_LO = 10;
    localparam int CA_IPHW_HI = 15;
    localparam int CA_BD      = 31;
    // Status bits software may change: IM[15:8], EXL, IE
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    // Interrupts report ExcCode 0; every other type is its own code
    function automatic logic [4:0] exc_code(input logic [31:0] t);
        return (t == EXC_INT) ? 5'd0 : t[4:0];
    endfunction
endpackage

// File: rtl/cp0_exc_ctrl_timer.sv
// cp0_timer: Count/Compare pair with clock divider and sticky timer interrupt.
//   i_count_we/i_compare_we : MTC0 write strobes, data on i_wdata
//   o_count/o_compare       : current register values
//   o_timer_int             : interrupt flag value for this cycle (set by match, cleared by Compare write)
module cp0_timer
    import cp0_defs::*;
#(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_timer_int
);
    localparam logic P_LAST = 1'(COUNT_DIV - 1);
    logic        r_phase, r_timer_int, w_tick, w_hit;
    logic [31:0] r_count, r_compare;
    assign w_tick      = r_phase == P_LAST;
    assign w_hit       = (r_count == r_compare) && (r_compare != '0);
    // A Compare write clears the flag even if a match happens in the same cycle
    assign o_timer_int = !i_compare_we && (r_timer_int || w_hit);
    assign o_count     = r_count;
    assign o_compare   = r_compare;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase     <= 1'b0;
            r_count     <= '0;
            r_compare   <= '0;
            r_timer_int <= 1'b0;
        end else begin
            r_phase     <= (i_count_we || w_tick) ? 1'b0 : ~r_phase;
            r_count     <= i_count_we ? i_wdata : r_count + 32'(w_tick);
            r_compare   <= i_compare_we ? i_wdata : r_compare;
            r_timer_int <= o_timer_int;
        end
    end
endmodule

// File: rtl/cp0_exc_ctrl.sv
// cp0_exc_ctrl: CP0 register bank and exception/ERET sequencer.
//   excepttype_i/bad_addr_i/pc_i/in_dslot_i : M-stage exception result to commit
//   we_i/waddr_i/wdata_i                    : MTC0 write port
//   raddr_i -> rdata_o                      : MFC0 read port (combinational)
//   hw_int_i                                : external interrupts into Cause.IP[14:10]
//   status_o/cause_o/epc_o                  : register views for the decoder
//   flush_o/newpc_o                         : same-cycle flush and redirect target
module cp0_exc_ctrl
    import cp0_defs::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] bad_addr_i,
    input  logic [31:0] pc_i,
    input  logic        in_dslot_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr_i,
    output logic [31:0] rdata_o,
    input  logic [4:0]  hw_int_i,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic        flush_o,
    output logic [31:0] newpc_o
);
    logic [31:0] r_status, r_cause, r_epc, r_badvaddr, w_count, w_compare;
    logic        w_eret, w_exc, w_wen, w_timer_int;
    assign w_eret   = excepttype_i == EXC_ERET;
    assign w_exc    = (excepttype_i != EXC_NONE) && !w_eret;
    // Any flushing instruction (exception or ERET) drops a concurrent MTC0
    assign w_wen    = we_i && (excepttype_i == EXC_NONE);
    assign flush_o  = excepttype_i != EXC_NONE;
    assign newpc_o  = w_eret ? r_epc : EXC_VECTOR;
    assign status_o = r_status;
    assign cause_o  = r_cause;
    assign epc_o    = r_epc;
    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_wen && (waddr_i == REG_COUNT)),
        .i_compare_we (w_wen && (waddr_i == REG_COMPARE)),
        .i_wdata      (wdata_i),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_timer_int  (w_timer_int)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status   <= STATUS_RST;
            r_cause    <= '0;
            r_epc      <= '0;
            r_badvaddr <= '0;
        end else begin
            r_cause[CA_IPHW_HI:CA_IPHW_LO] <= {w_timer_int, hw_int_i};
            if (w_exc) begin
                r_epc                        <= in_dslot_i ? pc_i - 32'd4 : pc_i;
                r_cause[CA_BD]               <= in_dslot_i;
                r_cause[CA_EXC_HI:CA_EXC_LO] <= exc_code(excepttype_i);
                r_status[ST_EXL]             <= 1'b1;
                if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES)
                    r_badvaddr <= bad_addr_i;
            end else if (w_eret) begin
                r_status[ST_EXL] <= 1'b0;
            end else if (w_wen) begin
                if (waddr_i == REG_STATUS)
                    r_status <= (r_status & ~STATUS_WMASK) | (wdata_i & STATUS_WMASK);
                if (waddr_i == REG_CAUSE)
                    r_cause[CA_IPSW_HI:CA_IPSW_LO] <= wdata_i[CA_IPSW_HI:CA_IPSW_LO];
                if (waddr_i == REG_EPC)
                    r_epc <= wdata_i;
            end
        end
    end
    always_comb begin
        rdata_o = '0;
        case (raddr_i)
            REG_BADVADDR: rdata_o = r_badvaddr;
            REG_COUNT:    rdata_o = w_count;
            REG_COMPARE:  rdata_o = w_compare;
            REG_STATUS:   rdata_o = r_status;
            REG_CAUSE:    rdata_o = r_cause;
            REG_EPC:      rdata_o = r_epc;
            default:      rdata_o = '0;
        endcase
    end
endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb_cp0_exc_ctrl: table-driven MTC0/MFC0 vectors plus scoreboarded exception, timer and reset sequences.
module tb_cp0_exc_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] excepttype_i, bad_addr_i, pc_i, wdata_i;
    logic [31:0] rdata_o, status_o, cause_o, epc_o, newpc_o;
    logic        in_dslot_i, we_i, flush_o;
    logic [4:0]  waddr_i, raddr_i, hw_int_i;
    int checks = 0, errors = 0;
    localparam int S_STATUS = 32, S_CAUSE = 33, S_EPC = 34, S_IP = 35;
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;
    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] exp;
        string       name;
    } vec_t;
    exp_t sb[$];
    vec_t vecs[10];
    cp0_exc_ctrl #(
        .EXC_VECTOR (32'hBFC0_0380),
        .STATUS_RST (32'h0040_0000),
        .COUNT_DIV  (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .excepttype_i (excepttype_i),
        .bad_addr_i   (bad_addr_i),
        .pc_i         (pc_i),
        .in_dslot_i   (in_dslot_i),
        .we_i         (we_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .raddr_i      (raddr_i),
        .rdata_o      (rdata_o),
        .hw_int_i     (hw_int_i),
        .status_o     (status_o),
        .cause_o      (cause_o),
        .epc_o        (epc_o),
        .flush_o      (flush_o),
        .newpc_o      (newpc_o)
    );
    always #10 clk = ~clk;
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask
    task automatic push(input string n, input int s, input logic [31:0] e);
        sb.push_back('{n, s, e});
    endtask
    // Compare every queued expectation against the DUT after the clock edge
    task automatic drain();
        exp_t        it;
        logic [31:0] act;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            if (it.sel < 32) begin
                raddr_i = 5'(it.sel);
                #1;
                act = rdata_o;
            end else begin
                act = (it.sel == S_STATUS) ? status_o :
                      (it.sel == S_CAUSE)  ? cause_o  :
                      (it.sel == S_EPC)    ? epc_o    : {24'h0, cause_o[15:8]};
            end
            chk(it.name, act, it.exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask
    task automatic set_idle();
        excepttype_i = '0;
        bad_addr_i   = '0;
        pc_i         = '0;
        in_dslot_i   = 1'b0;
        we_i         = 1'b0;
        waddr_i      = '0;
        wdata_i      = '0;
        hw_int_i     = '0;
    endtask
    task automatic mtc0(input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        set_idle();
        we_i    = 1'b1;
        waddr_i = wa;
        wdata_i = wd;
        #1;
    endtask
    task automatic exc(input logic [31:0] t, input logic [31:0] pc, input logic [31:0] ba, input logic ds);
        @(negedge clk);
        set_idle();
        excepttype_i = t;
        pc_i         = pc;
        bad_addr_i   = ba;
        in_dslot_i   = ds;
        #1;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{5'd12, 32'hFFFF_FFFF, 32'h0040_FF03, "status_wmask"};
        vecs[1] = '{5'd12, 32'h0000_0000, 32'h0040_0000, "status_clear_bev_kept"};
        vecs[2] = '{5'd13, 32'hFFFF_FFFF, 32'h0000_0300, "cause_wmask"};
        vecs[3] = '{5'd13, 32'h0000_0000, 32'h0000_0000, "cause_clear"};
        vecs[4] = '{5'd14, 32'h1234_5678, 32'h1234_5678, "epc_write"};
        vecs[5] = '{5'd11, 32'hFFFF_0000, 32'hFFFF_0000, "compare_write"};
        vecs[6] = '{5'd8,  32'hDEAD_BEEF, 32'h0000_0000, "badvaddr_readonly"};
        vecs[7] = '{5'd10, 32'hFFFF_FFFF, 32'h0000_0000, "unimpl_reg10"};
        vecs[8] = '{5'd9,  32'h0000_1000, 32'h0000_1000, "count_write"};
        vecs[9] = '{5'd15, 32'h5555_AAAA, 32'h0000_0000, "unimpl_reg15"};
        set_idle();
        raddr_i = 5'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_status", status_o, 32'h0040_0000);
        chk("rst_cause", cause_o, 32'h0);
        chk("rst_epc", epc_o, 32'h0);
        chk("rst_count", rdata_o, 32'h0);
        chk("rst_flush", {31'h0, flush_o}, 32'h0);
        chk("rst_newpc", newpc_o, 32'hBFC0_0380);
        rst = 1'b0;
        foreach (vecs[i]) begin
            mtc0(vecs[i].wa, vecs[i].wd);
            chk("mtc0_no_flush", {31'h0, flush_o}, 32'h0);
            push(vecs[i].name, int'(vecs[i].wa), vecs[i].exp);
            tick();
        end
        mtc0(5'd14, 32'hAAAA_5555);
        raddr_i = 5'd14;
        #1;
        chk("mfc0_no_bypass", rdata_o, 32'h1234_5678);
        push("epc_after_write", S_EPC, 32'hAAAA_5555);
        tick();
        exc(32'h8, 32'hBFC0_0104, 32'h0, 1'b1);
        chk("sys_flush", {31'h0, flush_o}, 32'h1);
        chk("sys_newpc", newpc_o, 32'hBFC0_0380);
        push("sys_epc_dslot", S_EPC, 32'hBFC0_0100);
        push("sys_cause", S_CAUSE, 32'h8000_0020);
        push("sys_status_exl", S_STATUS, 32'h0040_0002);
        tick();
        exc(32'h4, 32'h8000_0010, 32'h0000_1003, 1'b0);
        chk("adel_newpc", newpc_o, 32'hBFC0_0380);
        push("adel_badvaddr", 8, 32'h0000_1003);
        push("adel_cause", S_CAUSE, 32'h0000_0010);
        push("adel_epc", S_EPC, 32'h8000_0010);
        tick();
        exc(32'he, 32'h0, 32'h0, 1'b0);
        chk("eret_flush", {31'h0, flush_o}, 32'h1);
        chk("eret_newpc", newpc_o, 32'h8000_0010);
        push("eret_status", S_STATUS, 32'h0040_0000);
        push("eret_epc_kept", S_EPC, 32'h8000_0010);
        push("eret_cause_kept", S_CAUSE, 32'h0000_0010);
        tick();
        exc(32'h1, 32'h8000_0100, 32'hFFFF_FFFF, 1'b1);
        push("int_cause", S_CAUSE, 32'h8000_0000);
        push("int_epc", S_EPC, 32'h8000_00FC);
        push("int_badvaddr_kept", 8, 32'h0000_1003);
        tick();
        exc(32'h5, 32'h8000_0020, 32'h0000_2002, 1'b0);
        push("ades_badvaddr", 8, 32'h0000_2002);
        push("ades_cause", S_CAUSE, 32'h0000_0014);
        tick();
        exc(32'ha, 32'h8000_0030, 32'hFFFF_0000, 1'b0);
        push("ri_badvaddr_kept", 8, 32'h0000_2002);
        push("ri_cause", S_CAUSE, 32'h0000_0028);
        tick();
        exc(32'hc, 32'h8000_0200, 32'h0, 1'b0);
        we_i    = 1'b1;
        waddr_i = 5'd14;
        wdata_i = 32'h0000_1234;
        push("ov_mtc0_dropped_epc", S_EPC, 32'h8000_0200);
        push("ov_cause", S_CAUSE, 32'h0000_0030);
        tick();
        exc(32'he, 32'h0, 32'h0, 1'b0);
        we_i    = 1'b1;
        waddr_i = 5'd12;
        wdata_i = 32'h0000_FF01;
        #1;
        chk("eret2_newpc", newpc_o, 32'h8000_0200);
        push("eret_mtc0_dropped", S_STATUS, 32'h0040_0000);
        tick();
        @(negedge clk);
        set_idle();
        hw_int_i = 5'b10011;
        #1;
        chk("hwint_not_yet", {24'h0, cause_o[15:8]}, 32'h0);
        push("hwint_ip", S_IP, 32'h0000_004C);
        tick();
        @(negedge clk);
        set_idle();
        push("hwint_ip_clear", S_IP, 32'h0);
        tick();
        mtc0(5'd11, 32'h5);
        push("timer_compare", 11, 32'h5);
        tick();
        mtc0(5'd9, 32'h0);
        push("timer_count0", 9, 32'h0);
        tick();
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            set_idle();
            if (k == 10) begin
                push("count_at_5", 9, 32'h5);
                push("timer_ip_latency", S_IP, 32'h0);
            end
            if (k >= 11) push("timer_ip7_sticky", S_IP, 32'h80);
            tick();
        end
        mtc0(5'd11, 32'h0000_0100);
        push("timer_clear", S_IP, 32'h0);
        tick();
        @(negedge clk);
        set_idle();
        push("timer_stays_clear", S_IP, 32'h0);
        tick();
        mtc0(5'd9, 32'hFFFF_FFFF);
        push("wrap_load", 9, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        set_idle();
        push("wrap_phase1", 9, 32'hFFFF_FFFF);
        tick();
        @(negedge clk);
        set_idle();
        push("wrap_zero", 9, 32'h0);
        tick();
        exc(32'h8, 32'h8000_0400, 32'h0, 1'b0);
        push("pre_reset_exl", S_STATUS, 32'h0040_0002);
        tick();
        @(negedge clk);
        set_idle();
        raddr_i = 5'd9;
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_status", status_o, 32'h0040_0000);
        chk("midrst_cause", cause_o, 32'h0);
        chk("midrst_epc", epc_o, 32'h0);
        chk("midrst_count", rdata_o, 32'h0);
        chk("midrst_flush", {31'h0, flush_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        push("postrst_count", 9, 32'h0);
        push("postrst_status", S_STATUS, 32'h0040_0000);
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
